bin_to_bcd_seq: RTL and testbench

- Sequential binary-to-BCD converter using the shift-and-add-3 (double-dabble) algorithm.
- Converts a 32-bit processor output word into DIGITS packed BCD digits, plus a sign flag and an overflow flag.
- Sits directly upstream of the per-digit bcdtohex segment decoders in the board display path.
- Replaces the combinational divide/modulo chain with a 32-iteration multi-cycle datapath that uses one clock per iteration and no dividers.

---
 rtl/bin_to_bcd_seq_if.sv | 36 +++
 rtl/bin_to_bcd_seq.sv | 154 +++++++++++++++
 tb/tb_bin_to_bcd_seq.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/bin_to_bcd_seq_if.sv
// Handshake and result bundle between a value producer and the sequential
// binary-to-BCD converter.
interface bin_to_bcd_seq_if #(
    parameter int DIGITS = 6
);
    logic                  i_start;
    logic [31:0]           i_bin;
    logic                  i_signed;
    logic                  o_busy;
    logic                  o_done;
    logic [4*DIGITS-1:0]   o_bcd;
    logic                  o_sign;
    logic                  o_overflow;

    modport master (
        output i_start,
        output i_bin,
        output i_signed,
        input  o_busy,
        input  o_done,
        input  o_bcd,
        input  o_sign,
        input  o_overflow
    );

    modport slave (
        input  i_start,
        input  i_bin,
        input  i_signed,
        output o_busy,
        output o_done,
        output o_bcd,
        output o_sign,
        output o_overflow
    );
endinterface

// File: rtl/bin_to_bcd_seq.sv
// Sequential 32-bit binary to packed BCD converter (shift-and-add-3), one
// iteration per clock, with sign and overflow flags for the display path.
module bin_to_bcd_seq #(
    parameter int DIGITS = 6
) (
    input  logic               clk_i,
    input  logic               rst,
    bin_to_bcd_seq_if.slave    bus
);
    localparam int BCD_W = 4 * DIGITS;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [31:0]        mag_q, mag_d;
    logic [39:0]        acc_q, acc_d;
    logic [4:0]         count_q, count_d;
    logic               sign_q, sign_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [BCD_W-1:0]   bcd_q, bcd_d;
    logic               osign_q, osign_d;
    logic               ovf_q, ovf_d;

    logic [39:0]        adj_s;
    logic [39:0]        acc_sh_s;
    logic [31:0]        mag_sh_s;
    logic               cap_sign_s;

    // Add 3 to every BCD digit of the accumulator that is 5 or more.
    function automatic logic [39:0] add3_all(input logic [39:0] a);
        logic [39:0] r;
        r = a;
        for (int i = 0; i < 10; i++) begin
            if (a[4*i +: 4] >= 4'd5) begin
                r[4*i +: 4] = a[4*i +: 4] + 4'd3;
            end else begin
                r[4*i +: 4] = a[4*i +: 4];
            end
        end
        return r;
    endfunction

    // OR of all accumulator bits above the presented digits; constant 0 at DIGITS=10.
    function automatic logic hi_nonzero(input logic [39:0] a);
        logic r;
        r = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (i >= BCD_W) begin
                r = r | a[i];
            end else begin
                r = r;
            end
        end
        return r;
    endfunction

    // Next-state and datapath logic for one double-dabble iteration per cycle.
    always_comb begin
        state_d   = state_q;
        mag_d     = mag_q;
        acc_d     = acc_q;
        count_d   = count_q;
        sign_d    = sign_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        bcd_d     = bcd_q;
        osign_d   = osign_q;
        ovf_d     = ovf_q;

        adj_s      = add3_all(acc_q);
        acc_sh_s   = {adj_s[38:0], mag_q[31]};
        mag_sh_s   = {mag_q[30:0], 1'b0};
        cap_sign_s = bus.i_signed & bus.i_bin[31];

        case (state_q)
            ST_IDLE: begin
                busy_d = 1'b0;
                if (bus.i_start) begin
                    sign_d  = cap_sign_s;
                    mag_d   = cap_sign_s ? (~bus.i_bin + 32'd1) : bus.i_bin;
                    acc_d   = 40'd0;
                    count_d = 5'd0;
                    busy_d  = 1'b1;
                    state_d = ST_SHIFT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                acc_d   = acc_sh_s;
                mag_d   = mag_sh_s;
                count_d = count_q + 5'd1;
                busy_d  = 1'b1;
                // The result registers load from the final shifted value so
                // they are already valid during the DONE cycle.
                if (count_q == 5'd31) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                    bcd_d   = acc_sh_s[BCD_W-1:0];
                    ovf_d   = hi_nonzero(acc_sh_s);
                    osign_d = sign_q;
                end else begin
                    state_d = ST_SHIFT;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State, datapath and output registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst) begin
            state_q <= ST_IDLE;
            mag_q   <= 32'd0;
            acc_q   <= 40'd0;
            count_q <= 5'd0;
            sign_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            bcd_q   <= '0;
            osign_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            mag_q   <= mag_d;
            acc_q   <= acc_d;
            count_q <= count_d;
            sign_q  <= sign_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            bcd_q   <= bcd_d;
            osign_q <= osign_d;
            ovf_q   <= ovf_d;
        end
    end

    assign bus.o_busy     = busy_q;
    assign bus.o_done     = done_q;
    assign bus.o_bcd      = bcd_q;
    assign bus.o_sign     = osign_q;
    assign bus.o_overflow = ovf_q;
endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Self-checking bench for bin_to_bcd_seq: directed corner cases plus random
// words compared against an arithmetic (divide/modulo) reference model.
module tb_bin_to_bcd_seq;
    localparam int DIGITS = 6;
    localparam int BW     = 4 * DIGITS;

    logic clk_i = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk_i = ~clk_i;

    bin_to_bcd_seq_if #(.DIGITS(DIGITS)) bus ();

    bin_to_bcd_seq #(.DIGITS(DIGITS)) dut (
        .clk_i (clk_i),
        .rst   (rst),
        .bus   (bus)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: decimal digits by repeated division of the exact magnitude.
    task automatic model(input logic [31:0] b, input logic s,
                         output logic [BW-1:0] bcd, output logic sg, output logic ov);
        longint m;
        longint lim;
        sg  = s & b[31];
        m   = sg ? (64'sh1_0000_0000 - longint'(b)) : longint'(b);
        lim = 1;
        for (int i = 0; i < DIGITS; i++) lim = lim * 10;
        ov  = (m >= lim);
        bcd = '0;
        for (int i = 0; i < DIGITS; i++) begin
            bcd[4*i +: 4] = 4'(m % 10);
            m = m / 10;
        end
    endtask

    // Run one conversion; pa/pb are cycles after acceptance where a stray
    // i_start with value 777 is pulsed (0 = none). Inputs are scrambled meanwhile.
    task automatic convert(input logic [31:0] b, input logic s, input int pa, input int pb);
        logic [BW-1:0] e_bcd;
        logic          e_sg, e_ov;
        int            lat, busy_cnt;
        bit            seen;
        model(b, s, e_bcd, e_sg, e_ov);
        @(negedge clk_i);
        bus.i_start  = 1'b1;
        bus.i_bin    = b;
        bus.i_signed = s;
        @(posedge clk_i);
        #1;
        bus.i_start = 1'b0;
        lat = 0; busy_cnt = 0; seen = 1'b0;
        while (!seen && lat < 100) begin
            @(negedge clk_i);
            lat++;
            if (lat == pa || lat == pb) begin
                bus.i_start  = 1'b1;
                bus.i_bin    = 32'd777;
                bus.i_signed = 1'b0;
            end else begin
                bus.i_start  = 1'b0;
                bus.i_bin    = $urandom;
                bus.i_signed = 1'($urandom_range(0, 1));
            end
            if (bus.o_busy) busy_cnt++;
            if (bus.o_done) seen = 1'b1;
        end
        check_eq($sformatf("done_seen[%0h]", b), 64'(seen), 64'd1);
        check_eq($sformatf("latency[%0h]", b), 64'(lat), 64'd33);
        check_eq($sformatf("busy_cycles[%0h]", b), 64'(busy_cnt), 64'd33);
        check_eq($sformatf("bcd[%0h,%0d]", b, s), 64'(bus.o_bcd), 64'(e_bcd));
        check_eq($sformatf("sign[%0h,%0d]", b, s), 64'(bus.o_sign), 64'(e_sg));
        check_eq($sformatf("ovf[%0h,%0d]", b, s), 64'(bus.o_overflow), 64'(e_ov));
        @(negedge clk_i);
        bus.i_start = 1'b0;
        check_eq("done_single_pulse", 64'(bus.o_done), 64'd0);
        check_eq("idle_not_busy", 64'(bus.o_busy), 64'd0);
        check_eq("bcd_held", 64'(bus.o_bcd), 64'(e_bcd));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int  cnt;
        bit  seen;
        rst          = 1'b1;
        bus.i_start  = 1'b0;
        bus.i_bin    = 32'd0;
        bus.i_signed = 1'b0;
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        check_eq("rst_busy", 64'(bus.o_busy), 64'd0);
        check_eq("rst_done", 64'(bus.o_done), 64'd0);
        check_eq("rst_bcd", 64'(bus.o_bcd), 64'd0);
        check_eq("rst_sign", 64'(bus.o_sign), 64'd0);
        check_eq("rst_ovf", 64'(bus.o_overflow), 64'd0);
        rst = 1'b0;

        convert(32'd0, 1'b1, 0, 0);
        convert(32'd123456, 1'b0, 0, 0);
        convert(32'hFFFF_FFD6, 1'b1, 0, 0);
        convert(32'hFFFF_FFD6, 1'b0, 0, 0);
        convert(32'h8000_0000, 1'b1, 0, 0);
        convert(32'd999999, 1'b0, 0, 0);
        convert(32'd1000000, 1'b0, 0, 0);
        convert(32'hFFFF_FFFF, 1'b0, 0, 0);
        convert(32'd555, 1'b0, 5, 33);

        // Abort a conversion with rst in the 10th SHIFT cycle.
        @(negedge clk_i);
        bus.i_start  = 1'b1;
        bus.i_bin    = 32'd123;
        bus.i_signed = 1'b0;
        @(posedge clk_i);
        #1;
        bus.i_start = 1'b0;
        for (int k = 1; k <= 10; k++) @(negedge clk_i);
        rst         = 1'b1;
        bus.i_start = 1'b1;
        @(negedge clk_i);
        rst         = 1'b0;
        bus.i_start = 1'b0;
        check_eq("abort_busy", 64'(bus.o_busy), 64'd0);
        check_eq("abort_done", 64'(bus.o_done), 64'd0);
        check_eq("abort_bcd", 64'(bus.o_bcd), 64'd0);
        check_eq("abort_sign", 64'(bus.o_sign), 64'd0);
        check_eq("abort_ovf", 64'(bus.o_overflow), 64'd0);
        seen = 1'b0;
        cnt  = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk_i);
            if (bus.o_done || bus.o_busy) seen = 1'b1;
            cnt++;
        end
        check_eq("abort_no_activity", 64'(seen), 64'd0);
        convert(32'd321, 1'b0, 0, 0);

        for (int r = 0; r < 20; r++) begin
            logic [31:0] v;
            v = $urandom;
            if (r % 4 == 1) v = v % 32'd1000000;
            convert(v, 1'($urandom_range(0, 1)), 0, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
